// File: rtl/ext_pkg.sv
// Shared definitions for immediate-extension blocks.
// Mode encoding is common to every decode block that extends immediates.
// No logic, no latency, no backpressure.
package ext_pkg;

  localparam int EXT_MODE_W = 2;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_ZERO  = 2'd0,  // zero-extend
    EXT_SIGN  = 2'd1,  // sign-extend
    EXT_UPPER = 2'd2,  // place field in the top bits, low bits zero
    EXT_SHL   = 2'd3   // sign-extend, then shift left by SHAMT
  } ext_mode_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode, the immediate-extension stage and the ALU operand mux.
// Input side: flush, in_valid/in_ready, in_data, in_mode. Output side: out_valid/out_ready, out_data, count.
// master = upstream/downstream driver; slave = the extension stage.
interface imm_extend_pipe_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
);
  import ext_pkg::*;

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic [EXT_MODE_W-1:0] in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [1:0]            count;

  modport master (
    output flush, in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/imm_extend_comb.sv
// Purely combinational immediate extender: IN_WIDTH field -> OUT_WIDTH result by mode.
// Latency: zero cycles (combinational).
// Backpressure: none; ports are in_data, mode in, result out.
module imm_extend_comb
  import ext_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int SHAMT     = 2
) (
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [EXT_MODE_W-1:0] mode,
  output logic [OUT_WIDTH-1:0]  result
);

  logic [OUT_WIDTH-1:0] zext;
  logic [OUT_WIDTH-1:0] sext;
  logic [OUT_WIDTH-1:0] upper;
  logic [OUT_WIDTH-1:0] shl;

  // Casts keep the IN_WIDTH==OUT_WIDTH case free of zero-width replications.
  assign zext  = OUT_WIDTH'(in_data);
  assign sext  = OUT_WIDTH'(signed'(in_data));
  assign upper = zext << (OUT_WIDTH - IN_WIDTH);
  // Bits shifted past the MSB fall off; low bits fill with zero.
  assign shl   = sext << SHAMT;

  always_comb begin
    result = zext;
    case (ext_mode_e'(mode))
      EXT_ZERO:  result = zext;
      EXT_SIGN:  result = sext;
      EXT_UPPER: result = upper;
      EXT_SHL:   result = shl;
      default:   result = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage with a 2-entry output FIFO (decode -> ALU operand mux).
// Latency: one cycle from push to out_valid; full throughput when out_ready stays high.
// Backpressure: in_ready = (count != 2) from registered state only; out_data holds until popped.
// Ports: Clk, Rst (async, active-high), bus (slave modport: flush, in_*, out_*, count).
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int SHAMT     = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  imm_extend_pipe_if.slave     bus
);

  generate
    if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH || SHAMT < 0 || SHAMT >= OUT_WIDTH) begin : g_bad_params
      $error("imm_extend_pipe: illegal IN_WIDTH/OUT_WIDTH/SHAMT combination");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] ext_result;
  logic [OUT_WIDTH-1:0] mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count_q;
  logic                 push;
  logic                 pop;

  imm_extend_comb #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHAMT     (SHAMT)
  ) u_ext (
    .in_data (bus.in_data),
    .mode    (bus.in_mode),
    .result  (ext_result)
  );

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (bus.flush) begin
      // Flush wins over push/pop; stale slot contents are harmless once count is 0.
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ext_result;
        wr_ptr      <= ~wr_ptr;
      end
      // At count 1 a push+pop writes the other slot and moves the head onto it.
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (IN_WIDTH=16, OUT_WIDTH=32, SHAMT=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_imm_extend_pipe;
  import ext_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();

  imm_extend_pipe #(
    .IN_WIDTH  (16),
    .OUT_WIDTH (32),
    .SHAMT     (2)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_mode  = m;
  endtask

  logic [15:0] mode_in  [5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h4004};
  logic [1:0]  mode_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [31:0] mode_exp [5] = '{32'h00008001, 32'hFFFF8001, 32'h12340000, 32'hFFFFFFFC, 32'h00010010};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 2'd0);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    // 1. each mode, one-cycle latency, out_ready high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mode_in[i], mode_sel[i]);
      step();
      chk($sformatf("mode%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("mode%0d_data", i), bus.out_data, mode_exp[i]);
    end
    drive(1'b0, 16'h0, 2'd0);
    step();
    chk("mode_drain_valid", 32'(bus.out_valid), 32'd0);

    // 2. streaming: 8 back-to-back zero-extended pushes
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stream%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      drive(1'b1, 16'(16'h1000 + i), 2'd0);
      step();
      chk($sformatf("stream%0d_data", i), bus.out_data, 32'h00001000 + 32'(i));
      chk($sformatf("stream%0d_count", i), 32'(bus.count), 32'd1);
    end
    drive(1'b0, 16'h0, 2'd0);
    step();
    chk("stream_drain_count", 32'(bus.count), 32'd0);

    // 3. backpressure: A, B accepted, C held
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h000A, 2'd0);
    step();
    drive(1'b1, 16'h000B, 2'd0);
    step();
    chk("bp_count_full", 32'(bus.count), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h000C, 2'd0);
    step();
    chk("bp_count_held", 32'(bus.count), 32'd2);
    chk("bp_stall_data0", bus.out_data, 32'h0000000A);
    step();
    chk("bp_stall_data1", bus.out_data, 32'h0000000A);
    bus.out_ready = 1'b1;
    step();
    chk("bp_out_b", bus.out_data, 32'h0000000B);
    chk("bp_count_after_a", 32'(bus.count), 32'd1);
    step();
    chk("bp_out_c", bus.out_data, 32'h0000000C);
    chk("bp_count_after_b", 32'(bus.count), 32'd1);
    drive(1'b0, 16'h0, 2'd0);
    step();
    chk("bp_drain_count", 32'(bus.count), 32'd0);

    // 4. push and pop together at count 1
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h8000, 2'd1);
    step();
    chk("pp_first", bus.out_data, 32'hFFFF8000);
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0001, 2'd2);
    step();
    chk("pp_count", 32'(bus.count), 32'd1);
    chk("pp_replaced", bus.out_data, 32'h00010000);
    drive(1'b0, 16'h0, 2'd0);
    step();

    // 5. flush at count 2 and at count 1 with a push pending
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0011, 2'd0);
    step();
    drive(1'b1, 16'h0022, 2'd0);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 16'h0033, 2'd0);
    step();
    bus.flush = 1'b0;
    chk("flush2_count", 32'(bus.count), 32'd0);
    chk("flush2_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 16'h0044, 2'd0);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 16'h0055, 2'd0);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 2'd0);
    bus.out_ready = 1'b1;
    chk("flush1_count", 32'(bus.count), 32'd0);
    step();
    chk("flush1_no_output", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 16'h0066, 2'd0);
    step();
    chk("flush_next_data", bus.out_data, 32'h00000066);
    drive(1'b0, 16'h0, 2'd0);
    step();

    // 6. asynchronous reset with two entries held
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0077, 2'd0);
    step();
    drive(1'b1, 16'h0088, 2'd0);
    step();
    drive(1'b0, 16'h0, 2'd0);
    chk("arst_pre_count", 32'(bus.count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data", bus.out_data, 32'h0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    #2;
    rst = 1'b0;
    step();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hF00D, 2'd1);
    step();
    chk("arst_post_valid", 32'(bus.out_valid), 32'd1);
    chk("arst_post_data", bus.out_data, 32'hFFFFF00D);
    drive(1'b0, 16'h0, 2'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension stage for the core datapath; generalises the fixed 5-bit zero extender.
- Extends an IN_WIDTH field to OUT_WIDTH using a per-transaction mode: zero, sign, upper-placement or shifted sign-extend.
- Sits between decode and the ALU operand mux, with a valid/ready handshake and a 2-entry output buffer, so downstream stalls do not cost throughput.

Parameters:
IN_WIDTH, 16, width of immediate field; legal 1..OUT_WIDTH
OUT_WIDTH, 32, width of extended result
SHAMT, 2, left-shift amount for mode 3 (branch offsets); legal 0..OUT_WIDTH-1

Ports:
Clk  input  1  clock, rising-edge
Rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of buffered entries
in_valid  input  1  upstream has a transaction
in_ready  output  1  block can accept this cycle
in_data  input  IN_WIDTH  immediate field
in_mode  input  2  0 zero-ext, 1 sign-ext, 2 upper, 3 sign-ext shl SHAMT
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_data  output  OUT_WIDTH  extended result of head entry
count  output  2  entries held (0..2)

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous, active-high.
- Reset values: count=0, out_valid=0, out_data=0, both storage entries cleared, in_ready=1 (derived, count!=2).
- Extension arithmetic (combinational on input side, result stored on push):
  - mode 0: {(OUT_WIDTH-IN_WIDTH) zeros, in_data}.
  - mode 1: replicate in_data[IN_WIDTH-1] into the upper OUT_WIDTH-IN_WIDTH bits.
  - mode 2: in_data placed at [OUT_WIDTH-1 : OUT_WIDTH-IN_WIDTH], low bits zero. If IN_WIDTH==OUT_WIDTH, result = in_data.
  - mode 3: mode-1 result shifted left by SHAMT. Bits shifted past OUT_WIDTH-1 are discarded and low bits are zero-filled.
  - If IN_WIDTH==OUT_WIDTH, modes 0 and 1 both give in_data.
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2). It is a function of registered state only, with no combinational path from out_ready.
- Latency: data accepted at edge N is presented on out_data, with out_valid=1, after edge N (one-cycle latency). No bubble at full rate.
- Storage is a 2-entry FIFO (head/tail slots, or a 1-bit pointer pair). Order is strictly preserved.
- Counter transitions:
  - count 0: push → 1.
  - count 1: push & pop → 1 (head replaced by new data); push only → 2; pop only → 0.
  - count 2: push impossible; pop → 1 (tail becomes head).
- out_valid = (count != 0). out_data = head entry. It holds stable while out_valid & !out_ready; no change without a pop.
- Data on the input side is sampled only on push; in_data/in_mode are don't-care otherwise.
- flush: at the edge, count→0, out_valid→0, and any simultaneous push is discarded. flush has priority over push/pop.
- Rst asserted mid-transfer: all entries are lost immediately (asynchronous). The first push after deassertion is handled normally.
- Parameter checks: elaboration-time error if IN_WIDTH>OUT_WIDTH, IN_WIDTH<1, or SHAMT>=OUT_WIDTH.

Decomposition:
- Shared package `ext_pkg`: mode constants EXT_ZERO=2'd0, EXT_SIGN=2'd1, EXT_UPPER=2'd2, EXT_SHL=2'd3; the width of the mode field.
- One natural sub-module: `imm_extend_comb` (purely combinational: in_data and mode to result, same parameters), reused by other decode blocks.
- The FIFO/handshake control stays in `imm_extend_pipe`.

Test Plan:
All scenarios use IN_WIDTH=16, OUT_WIDTH=32, SHAMT=2.
1. Modes, out_ready=1:
   - 0x8001 mode0 → 0x00008001.
   - 0x8001 mode1 → 0xFFFF8001.
   - 0x1234 mode2 → 0x12340000.
   - 0xFFFF mode3 → 0xFFFFFFFC.
   - 0x4004 mode3 → 0x00010010.
   - Each result appears one cycle after push.
2. Streaming: 8 back-to-back pushes with out_ready=1 → 8 consecutive out_valid cycles, in order, in_ready never low, count constant 1.
3. Backpressure: out_ready=0, push A,B,C on consecutive cycles.
   - A and B are accepted, count=2, in_ready=0, and C is held.
   - Raise out_ready: outputs A then B then C in order.
   - out_data stays stable while stalled.
4. Simultaneous push/pop at count=1 → count stays 1, out_data updates to the new entry next cycle.
5. flush with count=2 and in_valid=1 → next cycle count=0, out_valid=0, and the pushed value is never output.
6. Rst asserted asynchronously between edges with count=2 → out_valid=0, out_data=0, count=0 immediately, in_ready=1. A push after release is output normally.
